// File: rtl/gpio_apb_bank.sv
// gpio_apb_bank: APB GPIO bank with pin control, synchronised inputs,
// atomic OUT set/clear and edge interrupts.
module gpio_apb_bank #(
   parameter int NPINS      = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic                  pselx,
   input  logic                  penable,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   input  logic [NPINS-1:0]      y,
   output logic [NPINS-1:0]      oe,
   output logic [NPINS-1:0]      pu,
   output logic [NPINS-1:0]      pd,
   output logic [NPINS-1:0]      a,
   output logic                  irq
);
   typedef enum logic {IDLE, RDATA} state_t;
   state_t r_state, w_next;
   logic [NPINS-1:0] r_oe, r_pu, r_pd, r_out, r_ie, r_ipol, r_istat;
   logic [NPINS-1:0] r_sync, r_ys, r_ys_d;
   logic [NPINS-1:0] w_wd, w_ev, w_rdata, w_clr;
   logic [DATA_WIDTH-1:0] r_prdata;
   logic [31:0] w_a;
   logic r_rerr, r_irq, w_acc, w_wr, w_rd, w_werr, w_rerr, w_unused;
   assign w_a      = 32'(paddr);
   assign w_wd     = pwdata[NPINS-1:0];
   assign w_unused = ^pwdata;
   assign w_acc    = pselx & penable;
   assign w_wr     = (r_state == IDLE) & w_acc & pwrite;
   assign w_rd     = (r_state == IDLE) & w_acc & ~pwrite;
   assign w_rerr   = w_a >= 32'd10;
   assign w_werr   = w_rerr | (w_a == 32'd4);
   assign w_ev     = (r_ipol & r_ys & ~r_ys_d) | (~r_ipol & ~r_ys & r_ys_d);
   assign w_clr    = (w_wr && w_a == 32'd9) ? w_wd : '0;
   always_comb begin
      w_next = r_state;
      pready = 1'b0;
      if (r_state == IDLE) begin
         pready = presetn & w_acc & pwrite;
         w_next = w_rd ? RDATA : IDLE;
      end else begin
         pready = 1'b1;
         w_next = IDLE;
      end
   end
   assign pslverr = pready & ((r_state == RDATA) ? r_rerr : w_werr);
   always_comb begin
      w_rdata = '0;
      case (w_a)
         32'd0:   w_rdata = r_oe;
         32'd1:   w_rdata = r_pu;
         32'd2:   w_rdata = r_pd;
         32'd3:   w_rdata = r_out;
         32'd4:   w_rdata = r_ys;
         32'd7:   w_rdata = r_ie;
         32'd8:   w_rdata = r_ipol;
         32'd9:   w_rdata = r_istat;
         default: w_rdata = '0;
      endcase
   end
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state  <= IDLE;
         r_oe     <= '0;
         r_pu     <= '0;
         r_pd     <= '0;
         r_out    <= '0;
         r_ie     <= '0;
         r_ipol   <= '0;
         r_istat  <= '0;
         r_sync   <= '0;
         r_ys     <= '0;
         r_ys_d   <= '0;
         r_prdata <= '0;
         r_rerr   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_sync  <= y;
         r_ys    <= r_sync;
         r_ys_d  <= r_ys;
         // new events take priority over a same-cycle W1C clear
         r_istat <= (r_istat & ~w_clr) | (w_ev & r_ie);
         r_irq   <= |(r_istat & r_ie);
         if (w_rd) begin
            r_prdata <= DATA_WIDTH'(w_rdata);
            r_rerr   <= w_rerr;
         end
         if (w_wr) begin
            if (w_a == 32'd0) r_oe   <= w_wd;
            if (w_a == 32'd1) r_pu   <= w_wd;
            if (w_a == 32'd2) r_pd   <= w_wd;
            if (w_a == 32'd3) r_out  <= w_wd;
            if (w_a == 32'd5) r_out  <= r_out | w_wd;
            if (w_a == 32'd6) r_out  <= r_out & ~w_wd;
            if (w_a == 32'd7) r_ie   <= w_wd;
            if (w_a == 32'd8) r_ipol <= w_wd;
         end
      end
   end
   assign oe     = r_oe;
   assign a      = r_out;
   assign pu     = r_pu & ~r_pd;
   assign pd     = r_pd & ~r_pu;
   assign irq    = r_irq;
   assign prdata = r_prdata;
endmodule

// File: doc/gpio_apb_bank.md
# gpio_apb_bank

Parametrised APB GPIO bank, the next generation of the fixed 8-pin GPIO register block. It provides direction, pull-up/pull-down and output-data registers plus a synchronised input register for NPINS pins. New over the previous generation: atomic set/clear of output data, edge-triggered interrupts with per-pin enable/polarity and a single irq line, PSLVERR reporting, and a defined one-wait-state read handshake. It sits between the APB interconnect and the pad ring; pad cells consume oe/pu/pd/a and return y.

## Interface
- NPINS, 8: number of GPIO pins, 1..32.
- ADDR_WIDTH, 4: paddr width; word index, one register per address.
- DATA_WIDTH, 32: APB data width; must be >= NPINS.

- pclk  in  1  APB clock; the only clock.
- presetn  in  1  reset, asynchronous, active-low.
- paddr  in  ADDR_WIDTH  register index.
- pwrite  in  1  1 = write, 0 = read.
- pselx  in  1  slave select.
- penable  in  1  APB access phase.
- pwdata  in  DATA_WIDTH  write data; bits [DATA_WIDTH-1:NPINS] ignored.
- prdata  out  DATA_WIDTH  read data; zero-extended above NPINS.
- pready  out  1  transfer complete.
- pslverr  out  1  error; valid only while pready=1.
- y  in  NPINS  pad input levels, asynchronous to pclk.
- oe, pu, pd, a  out  NPINS  output enable, pull-up, pull-down, output data.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map: 0 OE (RW), 1 PU (RW), 2 PD (RW), 3 OUT (RW), 4 IN (RO), 5 OUT_SET (WO, write-1-sets OUT bits), 6 OUT_CLR (WO, write-1-clears OUT bits), 7 IE (RW), 8 IPOL (RW, 1 = rising, 0 = falling), 9 ISTAT (RW1C). Addresses 10 and above are unmapped.
- Errors: pslverr=1 on any unmapped access and on writes to IN. Such writes have no effect; unmapped reads return 0. Reads of OUT_SET/OUT_CLR return 0 with pslverr=0.
- Pin outputs: oe=OE, a=OUT. Where PU[i] and PD[i] are both 1, pu[i] and pd[i] are both driven 0 (conflict suppression); otherwise pu=PU, pd=PD.
- Input path: 2-flop synchroniser on y gives ys; IN reads ys. A third flop holds ys_d for edge detection.
- Edge event on pin i: IPOL[i] ? (ys & ~ys_d) : (~ys & ys_d). An event with IE[i]=1 sets ISTAT[i]. Events with IE[i]=0 are discarded, not latched.
- ISTAT write: each 1 bit clears the corresponding ISTAT bit. If an event and a clear hit the same bit in the same cycle, set wins.
- irq = |(ISTAT & IE), registered. Clearing IE masks irq without clearing ISTAT.
- Handshake FSM, states IDLE and RDATA:
  - IDLE with pselx&penable&pwrite: pready=1 combinationally (zero wait). The write commits at that pclk edge. FSM stays in IDLE.
  - IDLE with pselx&penable&~pwrite: pready=0. prdata and pslverr are registered from paddr at that edge. FSM goes to RDATA.
  - RDATA: pready=1, prdata held. FSM returns to IDLE at the next edge unconditionally.
  - pselx low, or setup phase (penable=0): pready=0 and no register change.
- Reset values: all registers and outputs 0 (oe, pu, pd, a, irq, prdata, pready, pslverr). Synchroniser flops 0. FSM in IDLE.
- Reset mid-transfer: FSM returns to IDLE immediately. Any uncommitted write is lost.

## Timing
- Write: 2 APB cycles (setup + access). Register outputs update 1 cycle after the access edge.
- Read: 3 APB cycles (setup, access with pready=0, access with pready=1).
- y to IN visibility: 2 pclk edges.
- y edge to ISTAT set: 3 edges. ISTAT to irq: +1 edge.
- OUT_SET/OUT_CLR take effect on the same edge as an OUT write would.

## Test plan
- Reset: with presetn low, drive pwdata=all-ones writes -> all outputs stay 0, pready=0. After release, reads of registers 0–9 return 0.
- Pin controls, NPINS=8: write OE=0xA5 -> oe=8'hA5, pready high in the access cycle. Write PU=0x0F, then PD=0x03 -> pu=8'h0C, pd=8'h00; read PU -> 0x0F, with pready low for 1 cycle and high for 1 cycle.
- OUT atomics: write OUT=0x81, OUT_SET=0x10, OUT_CLR=0x01 -> a=0x81, then 0x91, then 0x90. Read OUT_SET -> 0, pslverr=0.
- Input sweep: y=0..255 -> each read of IN returns y once at least 2 cycles have passed since the change.
- Interrupts: IE=0x01, IPOL=0x01. y[0] 0→1 -> ISTAT=0x01, irq=1 after 4 edges; y[0] 1→0 -> no new set. Write ISTAT=0x01 on the same cycle as a new rising event -> ISTAT stays 1. Write IE=0 -> irq=0, ISTAT still reads 0x01.
- Errors: write to address 4, read and write address 12 -> pslverr=1 with pready, IN unchanged, read data 0. Assert presetn during the RDATA state -> pready=0 and all registers 0.
